// File: rtl/leg_alu_arbiter_if.sv
// leg_alu_arbiter_if: one requester's request/response handshake to the shared LEG ALU arbiter
//   req_valid/req_ready   request handshake carrying req_opcode, req_op1, req_op2
//   rsp_valid/rsp_ready   response handshake carrying rsp_data and rsp_err (illegal opcode)
//   master = requester side, slave = arbiter side
interface leg_alu_arbiter_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_opcode;
    logic [7:0] req_op1;
    logic [7:0] req_op2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    modport master (
        output req_valid, req_opcode, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/leg_alu_arbiter.sv
// leg_alu_arbiter: round-robin arbiter/sequencer giving two requesters turns on the shared 8-bit LEG ALU
//   clk, rst                       clock, asynchronous active-high reset
//   r0, r1                         requester handshakes (leg_alu_arbiter_if.slave)
//   alu_opcode, alu_op1, alu_op2   registered operands to the combinational ALU (0 outside EXEC)
//   alu_result                     combinational ALU output, captured in EXEC
module leg_alu_arbiter #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    PRIO_INIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    leg_alu_arbiter_if.slave         r0,
    leg_alu_arbiter_if.slave         r1,
    output logic [7:0]               alu_opcode,
    output logic [7:0]               alu_op1,
    output logic [7:0]               alu_op2,
    input  logic [7:0]               alu_result
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic [7:0] opc_q, opc_d;
    logic [7:0] op1_q, op1_d;
    logic [7:0] op2_q, op2_d;
    logic [7:0] result_q, result_d;
    logic       err_q, err_d;

    logic g0, g1, legal, exec, rsp0, rsp1, rsp_hs;
    logic unused_params;

    assign unused_params = (UUID != 0) ^ (NAME != "");

    // With both valid, the requester named by prio wins.
    assign g0     = r0.req_valid & (~r1.req_valid | ~prio_q);
    assign g1     = r1.req_valid & (~r0.req_valid | prio_q);
    assign legal  = opc_q <= 8'h0A;
    assign exec   = state_q == EXEC;
    assign rsp0   = state_q == RESP & ~owner_q;
    assign rsp1   = state_q == RESP & owner_q;
    assign rsp_hs = owner_q ? r1.rsp_ready : r0.rsp_ready;

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign r0.req_ready = ~rst & state_q == IDLE & g0;
    assign r1.req_ready = ~rst & state_q == IDLE & g1;

    // Illegal opcodes never reach the ALU.
    assign alu_opcode = exec & legal ? opc_q : 8'h00;
    assign alu_op1    = exec ? op1_q : 8'h00;
    assign alu_op2    = exec ? op2_q : 8'h00;

    assign r0.rsp_valid = rsp0;
    assign r0.rsp_data  = rsp0 ? result_q : 8'h00;
    assign r0.rsp_err   = rsp0 & err_q;
    assign r1.rsp_valid = rsp1;
    assign r1.rsp_data  = rsp1 ? result_q : 8'h00;
    assign r1.rsp_err   = rsp1 & err_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        opc_d    = opc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: if (g0 | g1) begin
                opc_d   = g1 ? r1.req_opcode : r0.req_opcode;
                op1_d   = g1 ? r1.req_op1 : r0.req_op1;
                op2_d   = g1 ? r1.req_op2 : r0.req_op2;
                owner_d = g1;
                prio_d  = ~g1;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = legal ? alu_result : 8'h00;
                err_d    = ~legal;
                state_d  = RESP;
            end
            RESP: state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'(PRIO_INIT);
            opc_q    <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            result_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            opc_q    <= opc_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_leg_alu_arbiter.sv
// tb_leg_alu_arbiter: directed and randomized checks of leg_alu_arbiter against a reference ALU and scoreboard
module tb_leg_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] v, rr, rdy, rv, re;
    logic [7:0] opc [2];
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [7:0] rd [2];
    logic [7:0] alu_opcode, alu_op1, alu_op2, alu_result;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] t;
        t = {x, x};
        case (op)
            8'd0: return x + y;
            8'd1: return x - y;
            8'd2: return x & y;
            8'd3: return x | y;
            8'd4: return ~x;
            8'd5: return x ^ y;
            8'd6: return x << y[2:0];
            8'd7: return x >> y[2:0];
            8'd8: begin t = t << y[2:0]; return t[15:8]; end
            8'd9: begin t = t >> y[2:0]; return t[7:0]; end
            8'd10: return x * y;
            default: return 8'hEE;
        endcase
    endfunction

    // {err, data} a requester must receive for an operation
    function automatic logic [8:0] ref_rsp(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y);
        return (op > 8'h0A) ? 9'h100 : {1'b0, alu_f(op, x, y)};
    endfunction

    leg_alu_arbiter_if r0_if ();
    leg_alu_arbiter_if r1_if ();

    assign r0_if.req_valid  = v[0];
    assign r0_if.req_opcode = opc[0];
    assign r0_if.req_op1    = a[0];
    assign r0_if.req_op2    = b[0];
    assign r0_if.rsp_ready  = rr[0];
    assign r1_if.req_valid  = v[1];
    assign r1_if.req_opcode = opc[1];
    assign r1_if.req_op1    = a[1];
    assign r1_if.req_op2    = b[1];
    assign r1_if.rsp_ready  = rr[1];
    assign rdy = {r1_if.req_ready, r0_if.req_ready};
    assign rv  = {r1_if.rsp_valid, r0_if.rsp_valid};
    assign re  = {r1_if.rsp_err, r0_if.rsp_err};
    assign rd[0] = r0_if.rsp_data;
    assign rd[1] = r1_if.rsp_data;
    assign alu_result = alu_f(alu_opcode, alu_op1, alu_op2);

    leg_alu_arbiter #(.UUID(7), .NAME("arb"), .PRIO_INIT(0)) dut (
        .clk(clk),
        .rst(rst),
        .r0(r0_if),
        .r1(r1_if),
        .alu_opcode(alu_opcode),
        .alu_op1(alu_op1),
        .alu_op2(alu_op2),
        .alu_result(alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int x, input logic [7:0] op, input logic [7:0] p, input logic [7:0] q);
        v[x] = 1'b1;
        opc[x] = op;
        a[x] = p;
        b[x] = q;
    endtask

    task automatic wait_ready(input int x);
        int n = 0;
        #1;
        while (!rdy[x] && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("req_ready", 32'(rdy[x]), 1);
    endtask

    task automatic issue(input int x, input logic [7:0] op, input logic [7:0] p, input logic [7:0] q);
        drive(x, op, p, q);
        wait_ready(x);
        step();
        v[x] = 1'b0;
    endtask

    task automatic get_rsp(input int x, input logic [7:0] op, input logic [7:0] p, input logic [7:0] q, input int hold);
        int n = 0;
        logic [8:0] e;
        e = ref_rsp(op, p, q);
        #1;
        while (!rv[x] && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("rsp_valid", 32'(rv[x]), 1);
        chk("rsp_other_quiet", {30'b0, rv[1-x], re[1-x]}, 0);
        chk("rsp_data_err", {re[x], rd[x]}, e);
        chk("no_grant_in_resp", 32'(rdy), 0);
        for (int i = 0; i < hold; i++) begin
            step();
            #1;
            chk("rsp_hold", {rv[x], re[x], rd[x]}, {1'b1, e});
            chk("no_grant_in_resp", 32'(rdy), 0);
        end
        rr[x] = 1'b1;
        step();
        rr[x] = 1'b0;
    endtask

    logic [9:0] sb [$];
    logic [9:0] e10;
    logic [1:0] acc;
    int last_g;
    logic [7:0] f_op [2][3];
    logic [7:0] f_a [2][3];
    logic [7:0] f_b [2][3];

    initial begin
        rst = 1'b1;
        v = 2'b00;
        rr = 2'b00;
        for (int i = 0; i < 2; i++) begin opc[i] = 0; a[i] = 0; b[i] = 0; end
        #1;
        chk("reset_alu", {8'b0, alu_opcode, alu_op1, alu_op2}, 0);
        chk("reset_hs", {26'b0, rdy, rv, re}, 0);
        chk("reset_rsp_data", {16'b0, rd[0], rd[1]}, 0);
        step();
        step();
        rst = 1'b0;

        // both valid straight out of reset: r0 holds priority
        drive(0, 8'd1, 8'h10, 8'h01);
        drive(1, 8'd10, 8'h10, 8'h11);
        #1;
        chk("both_grant_r0", 32'(rdy), 32'b01);
        step();
        v[0] = 1'b0;
        #1;
        chk("exec_no_grant", 32'(rdy), 0);
        chk("exec_alu", {8'b0, alu_opcode, alu_op1, alu_op2}, 32'h00011001);
        step();
        #1;
        chk("sub_rsp", {29'b0, rv, re[0]} , 32'b010);
        chk("sub_data", 32'(rd[0]), 32'h0F);
        chk("resp_no_grant", 32'(rdy), 0);
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;
        #1;
        chk("r1_after_hs", 32'(rdy), 32'b10);
        chk("idle_no_rsp", 32'(rv), 0);
        step();
        v[1] = 1'b0;
        get_rsp(1, 8'd10, 8'h10, 8'h11, 0);

        // single ADD on r0: ready at N, EXEC at N+1, response at N+2
        drive(0, 8'd0, 8'h12, 8'h34);
        #1;
        chk("add_ready", 32'(rdy), 32'b01);
        step();
        v[0] = 1'b0;
        #1;
        chk("add_exec_alu", {8'b0, alu_opcode, alu_op1, alu_op2}, 32'h00001234);
        chk("add_exec_no_rsp", 32'(rv), 0);
        step();
        #1;
        chk("add_rsp_valid", 32'(rv), 32'b01);
        chk("add_rsp", {re[0], rd[0]}, 9'h046);
        chk("add_r1_quiet", {re[1], rd[1]}, 0);
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;

        // backpressure on r1 with r0 waiting
        issue(1, 8'd8, 8'h81, 8'h01);
        drive(0, 8'd3, 8'h0C, 8'h30);
        get_rsp(1, 8'd8, 8'h81, 8'h01, 5);
        #1;
        chk("pending_grant", 32'(rdy), 32'b01);
        step();
        v[0] = 1'b0;
        get_rsp(0, 8'd3, 8'h0C, 8'h30, 0);

        // illegal opcodes, then a legal one clears err
        issue(0, 8'h0B, 8'h55, 8'h66);
        #1;
        chk("illegal_alu_opcode", 32'(alu_opcode), 0);
        get_rsp(0, 8'h0B, 8'h55, 8'h66, 0);
        issue(0, 8'd2, 8'hF3, 8'h3C);
        get_rsp(0, 8'd2, 8'hF3, 8'h3C, 0);
        issue(1, 8'hFF, 8'h01, 8'h02);
        get_rsp(1, 8'hFF, 8'h01, 8'h02, 0);

        // reset in EXEC after an r0 grant (which handed priority to r1)
        issue(0, 8'd0, 8'h01, 8'h02);
        #1;
        chk("pre_reset_exec", 32'(alu_op2), 32'h02);
        rst = 1'b1;
        f_op[0] = '{8'd0, 8'd1, 8'd4};   f_a[0] = '{8'h03, 8'h05, 8'hA5}; f_b[0] = '{8'h04, 8'h09, 8'h00};
        f_op[1] = '{8'd5, 8'd3, 8'd6};   f_a[1] = '{8'hF0, 8'h0F, 8'h0B}; f_b[1] = '{8'hFF, 8'h30, 8'h03};
        drive(0, f_op[0][0], f_a[0][0], f_b[0][0]);
        drive(1, f_op[1][0], f_a[1][0], f_b[1][0]);
        #1;
        chk("rst_alu", {8'b0, alu_opcode, alu_op1, alu_op2}, 0);
        chk("rst_hs", {26'b0, rdy, rv, re}, 0);
        chk("rst_rsp_data", {16'b0, rd[0], rd[1]}, 0);
        step();
        #1;
        chk("rst_held_hs", {28'b0, rdy, rv}, 0);
        rst = 1'b0;

        // six back-to-back ops with both valid alternate r0,r1,...
        for (int k = 0; k < 6; k++) begin
            int x, idx;
            x = k % 2;
            idx = k / 2;
            #1;
            chk("fair_grant", 32'(rdy), x ? 32'b10 : 32'b01);
            chk("fair_no_stale_rsp", 32'(rv), 0);
            step();
            if (idx < 2) drive(x, f_op[x][idx+1], f_a[x][idx+1], f_b[x][idx+1]);
            else v[x] = 1'b0;
            get_rsp(x, f_op[x][idx], f_a[x][idx], f_b[x][idx], 0);
        end
        v = 2'b00;

        // random traffic against a one-outstanding scoreboard
        last_g = 1;
        for (int c = 0; c < 600; c++) begin
            rr = 2'($urandom);
            for (int x = 0; x < 2; x++)
                if (!v[x] && $urandom_range(0, 2) == 0)
                    drive(x, 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            #1;
            acc = 2'b00;
            chk("ready_exclusive", 32'(&rdy), 0);
            for (int x = 0; x < 2; x++) begin
                if (rdy[x]) begin
                    if (&v) chk("rr_alternate", x, 1 - last_g);
                    sb.push_back({1'(x), ref_rsp(opc[x], a[x], b[x])});
                    last_g = x;
                    acc[x] = 1'b1;
                end
                if (!rv[x]) chk("idle_rsp_zero", {re[x], rd[x]}, 0);
                else if (rr[x]) begin
                    chk("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e10 = sb.pop_front();
                        chk("sb_rsp", {1'(x), re[x], rd[x]}, e10);
                    end
                end
            end
            chk("single_outstanding", 32'(sb.size() <= 1), 1);
            step();
            v = v & ~acc;
        end
        v = 2'b00;
        rr = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            for (int x = 0; x < 2; x++)
                if (rv[x] && sb.size() > 0) begin
                    e10 = sb.pop_front();
                    chk("drain_rsp", {1'(x), re[x], rd[x]}, e10);
                end
            step();
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle", 32'(rv), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/leg_alu_arbiter.md
# leg_alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit LEG ALU. The CPU execute stage and an auxiliary engine (checksum/DMA) each present opcode and operands over a valid/ready handshake. The block grants one requester at a time round-robin, drives the ALU from registered operands, captures the result, and returns it over a response handshake. It sits between the requesters and the combinational ALU, which it owns exclusively.

## Interface
Parameters:
- UUID, 0, instance identifier, codebase standard
- NAME, "", instance name, codebase standard
- PRIO_INIT, 0, requester that holds priority after reset (0 or 1)

Ports (x = 0 or 1; one set per requester):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_req_valid  in  1  request present
- rx_req_ready  out  1  request accepted this cycle
- rx_req_opcode  in  8  ALU opcode
- rx_req_op1  in  8  operand 1
- rx_req_op2  in  8  operand 2
- rx_rsp_valid  out  1  result available
- rx_rsp_ready  in  1  requester takes result
- rx_rsp_data  out  8  result
- rx_rsp_err  out  1  opcode was illegal
- alu_opcode  out  8  to ALU OPCODE
- alu_op1  out  8  to ALU OP1
- alu_op2  out  8  to ALU OP2
- alu_result  in  8  from ALU Output (combinational)

## Operation
- State machine: IDLE, EXEC, RESP. Registers: state, owner (1 bit), prio (1 bit), opcode/op1/op2 latches, result (8), err (1).
- IDLE grant:
  - only one rx_req_valid high: grant it.
  - both high: grant requester == prio.
  - grant asserts that requester's rx_req_ready combinationally (same cycle). At the edge, latch its fields, set owner, set prio = other requester, go to EXEC.
- IDLE with no request: stay. req_ready low for both.
- EXEC (one cycle):
  - drive alu_opcode/op1/op2 from latches.
  - legal opcode (0x00–0x0A: ADD, SUB, AND, OR, NOT, XOR, SHL, SHR, ROL, ROR, MUL): result <= alu_result, err <= 0.
  - illegal opcode (0x0B–0xFF, all 8 bits checked): drive alu_opcode = 0x00, result <= 0x00, err <= 1.
  - go to RESP.
- RESP:
  - owner's rsp_valid = 1; rsp_data = result, rsp_err = err, all held stable until rsp_ready.
  - on rsp_valid & rsp_ready: go to IDLE.
  - no new request is accepted in RESP.
- Non-owner rsp_valid = 0 always. rsp_data and rsp_err are 0 on a port whose rsp_valid is low.
- ALU inputs are 0x00 in IDLE and RESP. Arithmetic width and wrap are defined by the ALU (8-bit, low byte kept, e.g. MUL keeps low 8 bits).
- Requesters must hold valid and fields stable until ready. The arbiter does not check this.

## Timing
- Reset (async, immediate):
  - state = IDLE, prio = PRIO_INIT, owner = 0, latches/result/err = 0.
  - all outputs 0 while rst is high.
  - reset during EXEC or RESP drops the operation; no response is ever issued for it.
- Latency: request handshake in cycle N; EXEC in N+1; rsp_valid high in N+2.
- Minimum occupancy is 3 cycles per operation. Earliest next grant is the cycle after the response handshake.
- req_ready is a combinational function of state, prio and both req_valid. rsp_valid is registered (decoded from state).
- Fairness: with both requesters continuously valid, grants alternate strictly.

## Test plan
- r0 ADD 0x12, 0x34 issued at N:
  - r0_req_ready=1 at N, alu_opcode=0x00 at N+1.
  - r0_rsp_valid=1 at N+2 with data 0x46, err 0.
  - r1 sees no response.
- r0 SUB 0x10,0x01 and r1 MUL 0x10,0x11 both valid from reset (PRIO_INIT=0):
  - r0 served first, returns 0x0F.
  - r1 granted the cycle after r0's rsp handshake, returns 0x10.
- Backpressure: r1 ROL 0x81,1, r1_rsp_ready held low 5 cycles:
  - rsp_valid/data=0x03 held stable throughout.
  - r0 request pending meanwhile gets no ready until the r1 handshake.
- Illegal opcode 0x0B from r0:
  - alu_opcode=0x00 in EXEC.
  - r0_rsp_data=0x00, r0_rsp_err=1.
  - next legal op returns err=0.
- Assert rst in EXEC cycle:
  - all outputs 0 immediately.
  - after release: no rsp_valid, prio=PRIO_INIT, new request accepted in the first IDLE cycle.
- Both requesters valid for 6 back-to-back ops:
  - grant order r0,r1,r0,r1,r0,r1.
  - each response matches its own operands (e.g. r1 XOR 0xF0,0xFF -> 0x0F).
